fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, instruction queue entries; also the cap on queued plus in-flight fetches.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  XLEN  byte address of the requested word.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rsp_valid  input  1  in-order instruction word returned.
REQ-009 imem_rsp_data  input  ILEN  returned instruction.
REQ-010 redirect_valid  input  1  branch/jump redirect from execute.
REQ-011 redirect_pc  input  XLEN  redirect target.
REQ-012 if_valid  output  1  decode-side instruction valid.
REQ-013 if_pc  output  XLEN  PC of if_instr.
REQ-014 if_instr  output  ILEN  instruction to decode.
REQ-015 if_ready  input  1  decode consumes the head entry.
REQ-016 fetch_err  output  1  sticky fetch fault: misaligned or out-of-range PC.

Function
REQ-017 States: RUN and ERR; reset enters RUN.
REQ-018 RUN: imem_req_valid = 1 when (queue count + outstanding) < QDEPTH and the fetch PC is legal; otherwise 0.
REQ-019 A request transfers on imem_req_valid && imem_req_ready; the fetch PC then advances by 4 and outstanding increments.
REQ-020 Legal PC: pc[1:0] = 0 and pc < IMEM_SIZE.
REQ-021 An illegal fetch PC in RUN moves the unit to ERR on the next edge: fetch_err = 1, imem_req_valid = 0.
REQ-022 ERR is left only by a redirect; the redirect is evaluated for legality in the same way.
REQ-023 Response accept: an in-order response pushes {pc, imem_rsp_data} into the queue and decrements outstanding; the pushed PC is taken from a per-request PC tag FIFO.
REQ-024 The unit never back-pressures responses; the credit rule (REQ-018) guarantees a free queue slot.
REQ-025 Outputs if_valid, if_pc and if_instr are driven from the queue head; if_valid = queue not empty.
REQ-026 Pop on if_valid && if_ready.
REQ-027 Push and pop in the same cycle leave the count unchanged.
REQ-028 Minimum latency: response accepted in cycle N -> if_valid = 1 in cycle N+1.
REQ-029 Redirect effects:
- queue is flushed and the fetch PC is set to redirect_pc on the next edge;
- a drop counter is loaded with the outstanding count, including any request accepted that same cycle;
- fetch_err clears if redirect_pc is legal.
REQ-030 While the drop counter is nonzero, responses decrement it and are discarded; they count against credits until they return.
REQ-031 A redirect has priority over a simultaneous response, push, pop or request transfer: the same-cycle response is dropped, and a same-cycle pop is irrelevant.
REQ-032 No request is issued in the cycle redirect_valid is high.
REQ-033 PC arithmetic is modulo 2^XLEN; wrap beyond IMEM_SIZE is caught by REQ-020.

Reset
REQ-034 While rst_n = 0 at a clock edge:
- fetch PC = RESET_PC; queue, outstanding and drop counter = 0;
- state = RUN; imem_req_valid = 0, if_valid = 0, if_pc = 0, if_instr = 0, fetch_err = 0.
REQ-035 The first request issues in the first cycle after rst_n rises.
REQ-036 Reset mid-operation discards all in-flight responses; the memory is reset by the same rst_n.

Structure
REQ-037 riscv_pkg gains RESET_PC_DEFAULT, NOP_INSTR (32'h0000_0013) and typedef fetch_state_e {FS_RUN, FS_ERR}.
REQ-038 One sub-module, fetch_queue: a QDEPTH-entry synchronous FIFO of {pc, instr} with push, pop, flush, count, empty and full.
REQ-039 No other hierarchy.

Verification
REQ-040 Reset release, memory with 1-cycle latency, if_ready = 1 -> if_pc sequence 0x00, 0x04, 0x08; first if_valid 2 cycles after the first request accept.
REQ-041 if_ready = 0 for 6 cycles -> at most 2 requests are issued and the queue holds PCs 0x00 and 0x04; on release, both pop in order.
REQ-042 Redirect to 0x40 with 2 requests outstanding -> both responses are dropped; the next if_pc is 0x40.
REQ-043 Redirect to 0x42 -> fetch_err = 1, no requests issued; a later redirect to 0x10 -> fetch_err = 0 and if_pc = 0x10.
REQ-044 Sequential fetch reaching 0xFC then 0x100 with IMEM_SIZE = 256 -> 0xFC is delivered, fetch_err = 1, and 0x100 is never requested.
REQ-045 rst_n low for 1 cycle with a response pending -> the pending response is ignored and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: widths, reset PC, NOP encoding,
// fetch FSM states, queue entry layout and the PC legality check.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] IMEM_SIZE_DEFAULT = 32'h0000_0100;
  localparam logic [ILEN-1:0] NOP_INSTR         = 32'h0000_0013;

  typedef enum logic {
    FS_RUN,
    FS_ERR
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Word aligned and inside the instruction memory window.
  function automatic logic pc_legal(input logic [XLEN-1:0] pc,
                                    input logic [XLEN-1:0] size);
    return (pc[1:0] == 2'b00) && (pc < size);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
// Flush wins over push/pop; push when full and pop when empty are ignored.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= ptr_inc(r_wr);
      if (w_pop_ok)  r_rd <= ptr_inc(r_rd);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited in-order requests, PC tag FIFO,
// redirect with drop counting of stale responses, sticky fetch fault.
//
// state  | meaning
// FS_RUN | issuing requests while the fetch PC is legal and credits remain
// FS_ERR | fetch PC was illegal; no requests until a legal redirect
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              QDEPTH    = 2,
  parameter logic [XLEN-1:0] IMEM_SIZE = IMEM_SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  input  logic            if_ready,
  output logic            fetch_err
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_drop;
  logic [XLEN-1:0] r_tag [QDEPTH];
  logic [AW-1:0]   r_tag_wr;
  logic [AW-1:0]   r_tag_rd;

  logic            w_pc_ok;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_rsp;
  logic            w_dropping;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_q_count;
  logic            w_q_empty;
  logic            w_q_full;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;

  function automatic logic [AW-1:0] tag_inc(input logic [AW-1:0] p);
    return (p == AW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Queued plus in-flight entries may never exceed the queue depth, so a
  // returning response always has a slot and responses need no back-pressure.
  assign w_pc_ok  = pc_legal(r_pc, IMEM_SIZE);
  assign w_credit = !w_q_full &&
                    (({1'b0, w_q_count} + {1'b0, r_out}) < (CW + 1)'(QDEPTH));

  assign imem_req_valid = rst_n && (r_state == FS_RUN) && !redirect_valid &&
                          w_credit && w_pc_ok;
  assign imem_req_addr  = r_pc;

  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_rsp      = imem_rsp_valid && (r_out != '0);
  assign w_dropping = w_rsp && (r_drop != '0);
  assign w_push     = w_rsp && !w_dropping && !redirect_valid;
  assign w_pop      = !w_q_empty && if_ready && !redirect_valid;
  assign w_out_next = r_out + CW'(w_req_fire) - CW'(w_rsp);

  assign w_push_data.pc    = r_tag[r_tag_rd];
  assign w_push_data.instr = imem_rsp_data;

  assign if_valid  = !w_q_empty;
  assign if_pc     = w_q_empty ? '0 : w_head.pc;
  assign if_instr  = w_q_empty ? '0 : w_head.instr;
  assign fetch_err = (r_state == FS_ERR);

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_q_count),
    .o_empty (w_q_empty),
    .o_full  (w_q_full)
  );

  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_tag[r_tag_wr] <= r_pc;
    end
  end

  // Tags survive a redirect: stale responses still return and pop their tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= FS_RUN;
      r_pc     <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else begin
      r_out <= w_out_next;
      if (w_req_fire) r_tag_wr <= tag_inc(r_tag_wr);
      if (w_rsp)      r_tag_rd <= tag_inc(r_tag_rd);
      if (redirect_valid) begin
        r_pc    <= redirect_pc;
        r_drop  <= w_out_next;
        r_state <= pc_legal(redirect_pc, IMEM_SIZE) ? FS_RUN : FS_ERR;
      end else begin
        if (w_req_fire) r_pc   <= r_pc + 32'd4;
        if (w_dropping) r_drop <= r_drop - 1'b1;
        if (r_state == FS_RUN && !w_pc_ok) r_state <= FS_ERR;
      end
    end
  end

endmodule
